// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes width/digit slices, never narrower than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder assembled from half-adder cells.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);
    logic [DIGIT:0]   carry;
    logic [DIGIT-1:0] p, g_ab, g_pc;

    assign carry[0] = ci;

    // Each full-adder bit: half add the operands, then half add the carry in.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        half_adder u_ha_ab (.a(a[i]), .b(b[i]),     .s(p[i]), .c(g_ab[i]));
        half_adder u_ha_pc (.a(p[i]), .b(carry[i]), .s(s[i]), .c(g_pc[i]));
        assign carry[i+1] = g_ab[i] | g_pc[i];
    end

    assign co = carry[DIGIT];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial unsigned adder: one reused DIGIT-bit slice, start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    localparam int             N    = WIDTH / DIGIT;
    localparam int             CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra, rb, acc, acc_nxt;
    logic             k;
    logic [DIGIT-1:0] d;
    logic             ko;
    logic             load, last;

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .a  (ra[DIGIT-1:0]),
        .b  (rb[DIGIT-1:0]),
        .ci (k),
        .s  (d),
        .co (ko)
    );

    // Fresh digits enter at the MSB so the first one lands at bit 0 after N shifts.
    if (DIGIT == WIDTH) begin : g_one_shot
        assign acc_nxt = d;
    end else begin : g_shift
        assign acc_nxt = {d, acc[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            s    <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            ra   <= '0;
            rb   <= '0;
            acc  <= '0;
            k    <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= last;
            if (load) begin
                ra  <= a;
                rb  <= b;
                k   <= cin;
                cnt <= '0;
            end else if (state == RUN) begin
                ra  <= ra >> DIGIT;
                rb  <= rb >> DIGIT;
                k   <= ko;
                cnt <= cnt + CW'(1);
                acc <= acc_nxt;
                // Outputs only move on the final slice, so they hold during RUN.
                if (last) begin
                    s <= acc_nxt;
                    c <= ko;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across several WIDTH/DIGIT configurations.
module tb_serial_adder;

    localparam int NCFG = 5;

    function automatic int cfg_w(input int k);
        return (k == 4) ? 16 : 8;
    endfunction

    function automatic int cfg_d(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst   [NCFG];
    logic        start [NCFG];
    logic        cin   [NCFG];
    logic [15:0] a     [NCFG];
    logic [15:0] b     [NCFG];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit drain       = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cfg%0d cyc %0d: got %0h, want %0h", nm, id, cyc, got, want);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int D = cfg_d(g);
        localparam int N = W / D;

        logic         busy, done, c;
        logic [W-1:0] s;
        exp_t         q[$];
        int           last_acc = -1000;
        logic [31:0]  held = '0;

        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst   (rst[g]),
            .start (start[g]),
            .a     (a[g][W-1:0]),
            .b     (b[g][W-1:0]),
            .cin   (cin[g]),
            .busy  (busy),
            .done  (done),
            .s     (s),
            .c     (c)
        );

        // Reference: an add accepted at edge e finishes at e+N; the unit is free again after that.
        always @(posedge clk) begin : model
            int          e;
            logic [31:0] mask, sum;
            e = cyc + 1;
            if (rst[g]) begin
                last_acc = -1000;
                q.delete();
            end else if (start[g] && e > last_acc + N) begin
                mask = (32'd1 << W) - 32'd1;
                sum  = (32'(a[g]) & mask) + (32'(b[g]) & mask) + 32'(cin[g]);
                last_acc = e;
                q.push_back('{sum, e + N});
            end
        end

        always @(negedge clk) begin : monitor
            exp_t        e;
            logic [31:0] got;
            bit          exp_done;
            if (rst[g]) held = '0;
            got      = (32'(c) << W) | 32'(s);
            exp_done = (q.size() != 0) && (q[0].due == cyc);
            chk("busy", g, 32'(busy), 32'(cyc >= last_acc && cyc < last_acc + N));
            chk("done", g, 32'(done), 32'(exp_done));
            if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                if (done) held = e.val;
                chk("sum", g, got, e.val);
            end else begin
                chk("hold", g, got, held);
            end
            if (drain) chk("drain", g, 32'(q.size()), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive(input int i, input bit st, input logic [15:0] av, input logic [15:0] bv, input bit ci);
        start[i] = st;
        a[i]     = av;
        b[i]     = bv;
        cin[i]   = ci;
    endtask

    initial begin
        int sel;
        for (int i = 0; i < NCFG; i++) begin
            rst[i] = 1'b1;
            drive(i, 1'b0, 16'h0, 16'h0, 1'b0);
        end
        tick(3);
        for (int i = 0; i < NCFG; i++) rst[i] = 1'b0;
        tick(2);

        // 8/1: carry ripples through every bit
        drive(0, 1'b1, 16'h00FF, 16'h0001, 1'b0); tick(1);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);        tick(10);

        // 8/1: operands scrambled while running must not matter
        drive(0, 1'b1, 16'h005A, 16'h003C, 1'b1); tick(1);
        for (int k = 0; k < 9; k++) begin
            drive(0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            tick(1);
        end
        tick(2);

        // 16/4: all-ones plus all-ones plus one
        drive(4, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1); tick(1);
        drive(4, 1'b0, 16'h0, 16'h0, 1'b0);        tick(6);

        // 8/2: start held high gives back-to-back adds
        drive(1, 1'b1, 16'h0010, 16'h0020, 1'b0); tick(1);
        drive(1, 1'b1, 16'h0001, 16'h0002, 1'b0); tick(5);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);        tick(6);
        // start pulse mid-run is ignored
        drive(1, 1'b1, 16'h0044, 16'h0011, 1'b0); tick(1);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);        tick(1);
        drive(1, 1'b1, 16'h00AA, 16'h00AA, 1'b1); tick(1);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);        tick(6);

        // 8/1: reset in the fourth run cycle, then a fresh add
        drive(0, 1'b1, 16'h0033, 16'h0044, 1'b0); tick(1);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);        tick(3);
        rst[0] = 1'b1;
        drive(0, 1'b1, 16'h0077, 16'h0001, 1'b0); tick(1);
        rst[0] = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);        tick(12);
        drive(0, 1'b1, 16'h0001, 16'h0001, 1'b0); tick(1);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);        tick(10);

        // Random traffic on every configuration at once
        repeat (1200) begin
            for (int i = 0; i < NCFG; i++) begin
                sel = int'($urandom_range(0, 7));
                drive(i, 1'($urandom_range(0, 1)),
                      (sel == 0) ? 16'hFFFF : 16'($urandom),
                      (sel <= 1) ? 16'hFFFF : 16'($urandom),
                      1'($urandom_range(0, 1)));
            end
            tick(1);
        end
        for (int i = 0; i < NCFG; i++) drive(i, 1'b0, 16'h0, 16'h0, 1'b0);
        tick(20);

        drain = 1'b1;
        tick(1);
        drain = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
